a2_timer_run_ctrl: RTL and testbench

- Sequencer that drives the start/stop/standby controls of the a2_timer block: GOJ1, MSTRTP, MSTP, STRT2 and SBY.
- Turns host or monitor command pulses into timer-aligned control waveforms, tracks the run state, and flags a stalled timer.
- Sits between the monitor/test harness and a2_timer in the SIM_CLK domain.

---
 rtl/a2_timer_run_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_a2_timer_run_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/a2_timer_run_ctrl.sv
// a2_timer_run_ctrl: sequences the a2_timer start/stop/standby controls.
// Ports:
//   SIM_CLK, RESET_          - clock, async active-low reset
//   T12, STOP, GOJAM         - asynchronous timer status, synchronized here
//   CMD_GOJ..CMD_WAKE        - 1-cycle command pulses from host/monitor
//   GOJ1, MSTRTP, MSTP,
//   STRT2, SBY               - registered timer controls
//   STATE, BUSY              - run state and busy indication
//   STEP_DONE                - 1-cycle pulse when a single step completes
//   TMR_FAULT                - sticky watchdog flag (no T12 activity)
module a2_timer_run_ctrl #(
  parameter int unsigned POR_MCT  = 4,
  parameter int unsigned GOJ_CYC  = 16,
  parameter int unsigned STEP_CYC = 32,
  parameter int unsigned WDOG_CYC = 1024
) (
  input  logic       SIM_CLK,
  input  logic       RESET_,
  input  logic       T12,
  input  logic       STOP,
  input  logic       GOJAM,
  input  logic       CMD_GOJ,
  input  logic       CMD_HALT,
  input  logic       CMD_STEP,
  input  logic       CMD_RUN,
  input  logic       CMD_SBY,
  input  logic       CMD_WAKE,
  output logic       GOJ1,
  output logic       MSTRTP,
  output logic       MSTP,
  output logic       STRT2,
  output logic       SBY,
  output logic [3:0] STATE,
  output logic       BUSY,
  output logic       STEP_DONE,
  output logic       TMR_FAULT
);

  localparam int unsigned POR_W  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned WDOG_W = 12;

  typedef enum logic [3:0] {
    ST_POR       = 4'd0,
    ST_RUN       = 4'd1,
    ST_HALT_WAIT = 4'd2,
    ST_HALTED    = 4'd3,
    ST_STEP      = 4'd4,
    ST_STEP_WAIT = 4'd5,
    ST_SBY_WAIT  = 4'd6,
    ST_STANDBY   = 4'd7,
    ST_GOJ       = 4'd8,
    ST_GOJ_WAIT  = 4'd9
  } state_t;

  state_t              state, state_d;
  logic [POR_W-1:0]    por_cnt, por_cnt_d;
  logic [CNT_W-1:0]    cyc_cnt, cyc_cnt_d;
  logic [WDOG_W-1:0]   wdog_cnt, wdog_cnt_d;
  logic goj1, goj1_d, mstrtp, mstrtp_d, mstp, mstp_d, strt2, strt2_d;
  logic sby, sby_d, step_done, step_done_d, fault, fault_d, busy;
  logic t12_meta, t12_sync, t12_prev, t12_rise;
  logic stop_meta, stop_sync, gojam_meta, gojam_sync;
  logic wdog_active;

  // Input synchronizers; T12 rise is registered so the strobe lands 3 cycles after the edge
  always_ff @(posedge SIM_CLK or negedge RESET_) begin
    if (!RESET_) begin
      t12_meta   <= 1'b0;
      t12_sync   <= 1'b0;
      t12_prev   <= 1'b0;
      t12_rise   <= 1'b0;
      stop_meta  <= 1'b0;
      stop_sync  <= 1'b0;
      gojam_meta <= 1'b0;
      gojam_sync <= 1'b0;
    end else begin
      t12_meta   <= T12;
      t12_sync   <= t12_meta;
      t12_prev   <= t12_sync;
      t12_rise   <= t12_sync & ~t12_prev;
      stop_meta  <= STOP;
      stop_sync  <= stop_meta;
      gojam_meta <= GOJAM;
      gojam_sync <= gojam_meta;
    end
  end

  // Next-state, next-output and counter logic
  always_comb begin
    state_d     = state;
    por_cnt_d   = por_cnt;
    cyc_cnt_d   = cyc_cnt;
    wdog_cnt_d  = wdog_cnt;
    goj1_d      = goj1;
    mstrtp_d    = mstrtp;
    mstp_d      = mstp;
    strt2_d     = strt2;
    sby_d       = sby;
    step_done_d = 1'b0;
    fault_d     = fault;
    wdog_active = 1'b0;

    // GOJ outranks everything; the per-state branches then apply their own priority
    if (CMD_GOJ && (state != ST_POR)) begin
      state_d   = ST_GOJ;
      cyc_cnt_d = '0;
      goj1_d    = 1'b1;
      mstp_d    = 1'b0;
      sby_d     = 1'b0;
      mstrtp_d  = 1'b0;
      fault_d   = 1'b0;
    end else begin
      unique case (state)
        ST_POR: begin
          strt2_d = 1'b1;
          if (por_cnt == POR_W'(POR_MCT)) begin
            strt2_d = 1'b0;
            state_d = ST_RUN;
          end else if (t12_rise) begin
            por_cnt_d = por_cnt + POR_W'(1);
          end
        end
        ST_RUN: begin
          goj1_d   = 1'b0;
          mstrtp_d = 1'b0;
          mstp_d   = 1'b0;
          strt2_d  = 1'b0;
          sby_d    = 1'b0;
          if (CMD_SBY)       state_d = ST_SBY_WAIT;
          else if (CMD_HALT) state_d = ST_HALT_WAIT;
        end
        ST_HALT_WAIT: begin
          if (t12_rise) mstp_d = 1'b1;
          if (mstp && stop_sync) state_d = ST_HALTED;
        end
        ST_HALTED: begin
          mstp_d = 1'b1;
          if (CMD_STEP) begin
            state_d   = ST_STEP;
            cyc_cnt_d = '0;
            mstrtp_d  = 1'b1;
          end else if (CMD_RUN) begin
            mstp_d  = 1'b0;
            state_d = ST_RUN;
          end
        end
        ST_STEP: begin
          if (cyc_cnt == CNT_W'(STEP_CYC - 1)) begin
            mstrtp_d = 1'b0;
            state_d  = ST_STEP_WAIT;
          end else begin
            cyc_cnt_d = cyc_cnt + CNT_W'(1);
          end
        end
        ST_STEP_WAIT: begin
          if (t12_rise) begin
            step_done_d = 1'b1;
            state_d     = ST_HALTED;
          end
        end
        ST_SBY_WAIT: begin
          if (t12_rise) begin
            sby_d   = 1'b1;
            state_d = ST_STANDBY;
          end
        end
        ST_STANDBY: begin
          sby_d = 1'b1;
          if (CMD_WAKE) begin
            sby_d     = 1'b0;
            strt2_d   = 1'b1;
            por_cnt_d = '0;
            state_d   = ST_POR;
          end
        end
        ST_GOJ: begin
          if (cyc_cnt == CNT_W'(GOJ_CYC - 1)) begin
            goj1_d  = 1'b0;
            state_d = ST_GOJ_WAIT;
          end else begin
            cyc_cnt_d = cyc_cnt + CNT_W'(1);
          end
        end
        ST_GOJ_WAIT: begin
          if (!gojam_sync) state_d = ST_RUN;
        end
        default: state_d = ST_POR;
      endcase
    end

    // Watchdog: restarts on T12 activity or any state change, saturates at the limit
    wdog_active = (state == ST_POR) || (state == ST_RUN) || (state == ST_HALT_WAIT) ||
                  (state == ST_STEP_WAIT) || (state == ST_SBY_WAIT);
    if (!wdog_active || t12_rise || (state_d != state)) begin
      wdog_cnt_d = '0;
    end else if (wdog_cnt != WDOG_W'(WDOG_CYC)) begin
      wdog_cnt_d = wdog_cnt + WDOG_W'(1);
    end
    if (wdog_cnt_d == WDOG_W'(WDOG_CYC)) fault_d = 1'b1;
  end

  // State, counter and output registers
  always_ff @(posedge SIM_CLK or negedge RESET_) begin
    if (!RESET_) begin
      state     <= ST_POR;
      por_cnt   <= '0;
      cyc_cnt   <= '0;
      wdog_cnt  <= '0;
      goj1      <= 1'b0;
      mstrtp    <= 1'b0;
      mstp      <= 1'b0;
      strt2     <= 1'b1;
      sby       <= 1'b0;
      step_done <= 1'b0;
      fault     <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_d;
      por_cnt   <= por_cnt_d;
      cyc_cnt   <= cyc_cnt_d;
      wdog_cnt  <= wdog_cnt_d;
      goj1      <= goj1_d;
      mstrtp    <= mstrtp_d;
      mstp      <= mstp_d;
      strt2     <= strt2_d;
      sby       <= sby_d;
      step_done <= step_done_d;
      fault     <= fault_d;
      busy      <= !((state_d == ST_RUN) || (state_d == ST_HALTED) || (state_d == ST_STANDBY));
    end
  end

  assign GOJ1      = goj1;
  assign MSTRTP    = mstrtp;
  assign MSTP      = mstp;
  assign STRT2     = strt2;
  assign SBY       = sby;
  assign STATE     = state;
  assign BUSY      = busy;
  assign STEP_DONE = step_done;
  assign TMR_FAULT = fault;

endmodule

// File: tb/tb_a2_timer_run_ctrl.sv
// Directed self-checking bench for a2_timer_run_ctrl.
module tb_a2_timer_run_ctrl;

  logic       SIM_CLK, RESET_, T12, STOP, GOJAM;
  logic       CMD_GOJ, CMD_HALT, CMD_STEP, CMD_RUN, CMD_SBY, CMD_WAKE;
  logic       GOJ1, MSTRTP, MSTP, STRT2, SBY, BUSY, STEP_DONE, TMR_FAULT;
  logic [3:0] STATE;

  int checks   = 0;
  int failures = 0;
  int n;
  logic mstp_low;

  a2_timer_run_ctrl dut (
    .SIM_CLK(SIM_CLK), .RESET_(RESET_), .T12(T12), .STOP(STOP), .GOJAM(GOJAM),
    .CMD_GOJ(CMD_GOJ), .CMD_HALT(CMD_HALT), .CMD_STEP(CMD_STEP), .CMD_RUN(CMD_RUN),
    .CMD_SBY(CMD_SBY), .CMD_WAKE(CMD_WAKE),
    .GOJ1(GOJ1), .MSTRTP(MSTRTP), .MSTP(MSTP), .STRT2(STRT2), .SBY(SBY),
    .STATE(STATE), .BUSY(BUSY), .STEP_DONE(STEP_DONE), .TMR_FAULT(TMR_FAULT)
  );

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the edge
  task automatic step(input int cyc);
    repeat (cyc) @(posedge SIM_CLK);
    #1;
  endtask

  // T12 high for two cycles; caller sits 2 cycles after the input edge on return
  task automatic t12_pulse();
    T12 = 1'b1;
    step(2);
    T12 = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [3:0] exp, input int budget);
    int k;
    k = 0;
    while ((STATE !== exp) && (k < budget)) begin
      step(1);
      k++;
    end
    chk(tag, 16'(STATE), 16'(exp));
  endtask

  initial begin
    RESET_ = 1'b0; T12 = 1'b0; STOP = 1'b0; GOJAM = 1'b0;
    CMD_GOJ = 1'b0; CMD_HALT = 1'b0; CMD_STEP = 1'b0; CMD_RUN = 1'b0;
    CMD_SBY = 1'b0; CMD_WAKE = 1'b0;
    step(3);

    // Reset values
    chk("rst_strt2", 16'(STRT2), 16'd1);
    chk("rst_state", 16'(STATE), 16'd0);
    chk("rst_busy", 16'(BUSY), 16'd1);
    chk("rst_ctrl", 16'({GOJ1, MSTRTP, MSTP, SBY, STEP_DONE, TMR_FAULT}), 16'd0);

    // Power-on: STRT2 held for 4 T12 rises spaced 586 cycles
    RESET_ = 1'b1;
    step(10);
    for (int i = 0; i < 3; i++) begin
      t12_pulse();
      step(584);
    end
    chk("por_before4", 16'(STATE), 16'd0);
    t12_pulse();
    step(2);
    chk("por_strt2_hold", 16'(STRT2), 16'd1);
    step(1);
    chk("por_strt2_drop", 16'(STRT2), 16'd0);
    chk("por_run", 16'(STATE), 16'd1);
    chk("por_busy", 16'(BUSY), 16'd0);

    // Halt: MSTP at T12+4, HALTED once STOP is synced
    step(100);
    CMD_HALT = 1'b1; step(1); CMD_HALT = 1'b0;
    chk("halt_wait", 16'(STATE), 16'd2);
    chk("halt_busy", 16'(BUSY), 16'd1);
    step(198);
    t12_pulse();
    step(1);
    chk("halt_mstp_early", 16'(MSTP), 16'd0);
    step(1);
    chk("halt_mstp", 16'(MSTP), 16'd1);
    step(6);
    STOP = 1'b1;
    step(2);
    chk("halt_stop_sync", 16'(STATE), 16'd2);
    step(1);
    chk("halted", 16'(STATE), 16'd3);
    chk("halted_busy", 16'(BUSY), 16'd0);

    // Single step: MSTRTP for 32 cycles, STEP_DONE after the next T12 rise
    mstp_low = 1'b0;
    CMD_STEP = 1'b1; step(1); CMD_STEP = 1'b0;
    chk("step_state", 16'(STATE), 16'd4);
    n = MSTRTP ? 1 : 0;
    while (MSTRTP && (n < 100)) begin
      step(1);
      if (!MSTP) mstp_low = 1'b1;
      if (MSTRTP) n++;
    end
    chk("step_width", 16'(n), 16'd32);
    chk("step_wait", 16'(STATE), 16'd5);
    step(10);
    t12_pulse();
    step(1);
    chk("step_done_early", 16'(STEP_DONE), 16'd0);
    step(1);
    chk("step_done", 16'(STEP_DONE), 16'd1);
    chk("step_back_halted", 16'(STATE), 16'd3);
    if (!MSTP) mstp_low = 1'b1;
    step(1);
    chk("step_done_1cyc", 16'(STEP_DONE), 16'd0);
    chk("step_mstp_held", 16'(mstp_low), 16'd0);

    // GOJ and RUN together from HALTED: GOJ wins
    CMD_GOJ = 1'b1; CMD_RUN = 1'b1; step(1); CMD_GOJ = 1'b0; CMD_RUN = 1'b0;
    STOP = 1'b0;
    GOJAM = 1'b1;
    chk("goj_state", 16'(STATE), 16'd8);
    chk("goj_mstp", 16'(MSTP), 16'd0);
    n = GOJ1 ? 1 : 0;
    while (GOJ1 && (n < 100)) begin
      step(1);
      if (GOJ1) n++;
    end
    chk("goj_width", 16'(n), 16'd16);
    step(34);
    chk("goj_wait", 16'(STATE), 16'd9);
    GOJAM = 1'b0;
    step(2);
    chk("goj_wait_sync", 16'(STATE), 16'd9);
    step(1);
    chk("goj_run", 16'(STATE), 16'd1);

    // Watchdog: fault 1028 cycles after the T12 input edge (3 sync + 1 clear)
    chk("wdog_clear", 16'(TMR_FAULT), 16'd0);
    t12_pulse();
    step(1025);
    chk("wdog_before", 16'(TMR_FAULT), 16'd0);
    step(1);
    chk("wdog_fault", 16'(TMR_FAULT), 16'd1);
    step(5);
    chk("wdog_sticky", 16'(TMR_FAULT), 16'd1);
    chk("wdog_state", 16'(STATE), 16'd1);
    CMD_GOJ = 1'b1; step(1); CMD_GOJ = 1'b0;
    chk("wdog_goj_clr", 16'(TMR_FAULT), 16'd0);
    chk("wdog_goj1", 16'(GOJ1), 16'd1);
    wait_state("wdog_goj_run", 4'd1, 40);

    // Standby and wake
    CMD_SBY = 1'b1; step(1); CMD_SBY = 1'b0;
    chk("sby_wait", 16'(STATE), 16'd6);
    step(5);
    t12_pulse();
    step(1);
    chk("sby_early", 16'(SBY), 16'd0);
    step(1);
    chk("sby_set", 16'(SBY), 16'd1);
    chk("sby_state", 16'(STATE), 16'd7);
    CMD_WAKE = 1'b1; step(1); CMD_WAKE = 1'b0;
    chk("wake_sby", 16'(SBY), 16'd0);
    chk("wake_strt2", 16'(STRT2), 16'd1);
    chk("wake_state", 16'(STATE), 16'd0);
    for (int i = 0; i < 3; i++) begin
      t12_pulse();
      step(48);
    end
    t12_pulse();
    step(2);
    chk("wake_strt2_hold", 16'(STRT2), 16'd1);
    step(1);
    chk("wake_strt2_drop", 16'(STRT2), 16'd0);
    chk("wake_run", 16'(STATE), 16'd1);

    // Illegal commands dropped; SBY outranks HALT
    CMD_STEP = 1'b1; CMD_RUN = 1'b1; CMD_WAKE = 1'b1; step(1);
    CMD_STEP = 1'b0; CMD_RUN = 1'b0; CMD_WAKE = 1'b0;
    chk("drop_cmds", 16'(STATE), 16'd1);
    CMD_SBY = 1'b1; CMD_HALT = 1'b1; step(1); CMD_SBY = 1'b0; CMD_HALT = 1'b0;
    chk("prio_sby", 16'(STATE), 16'd6);
    CMD_GOJ = 1'b1; step(1); CMD_GOJ = 1'b0;
    wait_state("prio_goj_run", 4'd1, 40);

    // Reset asserted mid-step
    CMD_HALT = 1'b1; step(1); CMD_HALT = 1'b0;
    step(3);
    t12_pulse();
    step(3);
    STOP = 1'b1;
    wait_state("mid_halted", 4'd3, 20);
    CMD_STEP = 1'b1; step(1); CMD_STEP = 1'b0;
    step(4);
    chk("mid_mstrtp", 16'(MSTRTP), 16'd1);
    #2;
    RESET_ = 1'b0;
    #1;
    chk("async_mstrtp", 16'(MSTRTP), 16'd0);
    chk("async_strt2", 16'(STRT2), 16'd1);
    chk("async_mstp", 16'(MSTP), 16'd0);
    chk("async_state", 16'(STATE), 16'd0);
    STOP = 1'b0;
    step(2);
    RESET_ = 1'b1;
    step(2);
    chk("post_rst_state", 16'(STATE), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
